// File: rtl/board_reset_ctrl_pkg.sv
// Shared encodings and sizing helpers for the board reset/button front-end.
// Pure declarations; no logic, no latency.
package board_pkg;

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_HOLD  = 3'd1,
      S_STAGE = 3'd2,
      S_RUN   = 3'd3
   } rst_state_e;

   localparam int RST_COUNT_W = 8;

   // Width of a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/board_reset_ctrl_if.sv
// Board-side bundle: lock/buttons in, debounced buttons and staged resets out.
// master is the controller view, slave is the board/bench view.
interface board_reset_ctrl_if #(
   parameter int NUM_BTN = 2,
   parameter int NUM_RST = 2
);
   import board_pkg::*;

   logic                   pll_locked;
   logic [NUM_BTN-1:0]     btn_raw;
   logic [NUM_BTN-1:0]     btn_db;
   logic [NUM_BTN-1:0]     btn_rise;
   logic [NUM_BTN-1:0]     btn_fall;
   logic [NUM_RST-1:0]     sys_rst_n;
   logic [2:0]             rst_state;
   logic [RST_COUNT_W-1:0] rst_count;

   modport master (
      input  pll_locked, btn_raw,
      output btn_db, btn_rise, btn_fall, sys_rst_n, rst_state, rst_count
   );

   modport slave (
      output pll_locked, btn_raw,
      input  btn_db, btn_rise, btn_fall, sys_rst_n, rst_state, rst_count
   );
endinterface

// File: rtl/board_reset_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, polarity normalise, debounce, edge pulses.
// Raw step to btn_db change is 2 + DEBOUNCE_CYCLES cycles; rise/fall are registered.
module btn_debounce
   import board_pkg::*;
#(
   parameter int ACTIVE_HIGH     = 1,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);
   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          INV      = (ACTIVE_HIGH == 0);

   logic          sync1;
   logic          sync2;
   logic          sample;
   logic [CW-1:0] cnt;

   assign sample = sync2 ^ INV;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         db    <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sample == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            db   <= sample;
            rise <= sample;
            fall <= ~sample;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/board_reset_ctrl.sv
// Lock qualification, button debounce and staged glitch-free core resets.
// All outputs registered; abort (lock loss / reset button) pulls every reset low on the next edge.
module board_reset_ctrl
   import board_pkg::*;
#(
   parameter int NUM_BTN         = 2,
   parameter int BTN_ACTIVE_HIGH = 1,
   parameter int RST_BTN_IDX     = 0,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int NUM_RST         = 2,
   parameter int STAGE_GAP       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   board_reset_ctrl_if.master        bus
);
   localparam int            HW        = cnt_width(RST_HOLD_CYCLES);
   localparam int            GW        = cnt_width(STAGE_GAP);
   localparam int            IW        = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_RST - 1);

   logic [NUM_BTN-1:0] btn_db_w;
   logic [NUM_BTN-1:0] btn_rise_w;
   logic [NUM_BTN-1:0] btn_fall_w;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .ACTIVE_HIGH     (BTN_ACTIVE_HIGH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (bus.btn_raw[i]),
         .db   (btn_db_w[i]),
         .rise (btn_rise_w[i]),
         .fall (btn_fall_w[i])
      );
   end

   logic lock_s1;
   logic lock_s;

   rst_state_e             state_q,  state_d;
   logic [HW-1:0]          hold_q,   hold_d;
   logic [GW-1:0]          gap_q,    gap_d;
   logic [IW-1:0]          idx_q,    idx_d;
   logic [NUM_RST-1:0]     rst_q,    rst_d;
   logic [RST_COUNT_W-1:0] count_q,  count_d;
   logic                   abort;

   assign abort = !lock_s || btn_db_w[RST_BTN_IDX];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1 <= 1'b0;
         lock_s  <= 1'b0;
         state_q <= S_WAIT;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         count_q <= '0;
      end else begin
         lock_s1 <= bus.pll_locked;
         lock_s  <= lock_s1;
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      count_d = count_q;
      // Abort is checked ahead of the stage logic so a coinciding release never rises.
      if (state_q != S_WAIT && abort) begin
         state_d = S_WAIT;
         hold_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         rst_d   = '0;
         if (count_q != '1) count_d = count_q + 1'b1;
      end else begin
         case (state_q)
            S_WAIT: begin
               rst_d = '0;
               if (lock_s && !btn_db_w[RST_BTN_IDX]) begin
                  state_d = S_HOLD;
                  hold_d  = '0;
               end
            end
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d   = '0;
                  gap_d    = '0;
                  idx_d    = IW'(1);
                  rst_d[0] = 1'b1;
                  state_d  = (NUM_RST == 1) ? S_RUN : S_STAGE;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            S_STAGE: begin
               if (gap_q == GAP_LAST) begin
                  gap_d        = '0;
                  rst_d[idx_q] = 1'b1;
                  idx_d        = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) state_d = S_RUN;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            S_RUN: begin
               rst_d = '1;
            end
            default: begin
               state_d = S_WAIT;
               rst_d   = '0;
            end
         endcase
      end
   end

   assign bus.btn_db    = btn_db_w;
   assign bus.btn_rise  = btn_rise_w;
   assign bus.btn_fall  = btn_fall_w;
   assign bus.sys_rst_n = rst_q;
   assign bus.rst_state = 3'(state_q);
   assign bus.rst_count = count_q;
endmodule
